iob_eth_rx: RTL

MII receive-side engine for the Ethernet core: it samples the 4-bit PHY receive bus on RX_CLK and strips the preamble and SFD. It assembles bytes low nibble first and writes them into the RX frame buffer one byte per write strobe. At end of frame it presents the byte count, an error flag and a CRC status to the CPU-side logic, then holds until acknowledged. It is the receive counterpart of the MII transmitter, runs entirely in the RX_CLK domain, and leaves clock-domain crossing to the consumer.

---
 rtl/iob_eth_rx_if.sv | 27 ++
 rtl/iob_eth_rx.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_rx_if.sv
// Signal bundle for the MII receive engine: PHY receive inputs, frame-buffer
// write port and the completed-frame status / acknowledge handshake.
interface iob_eth_rx_if #(
  parameter int ADDR_W = 11
);
  logic              RX_DV;
  logic              RX_ER;
  logic [3:0]        RX_DATA;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data;
  logic              wr;
  logic              ready;
  logic [ADDR_W-1:0] nbytes;
  logic              err;
  logic              crc_ok;
  logic              rcv_ack;

  modport master (
    input  RX_DV, RX_ER, RX_DATA, rcv_ack,
    output addr, data, wr, ready, nbytes, err, crc_ok
  );

  modport slave (
    output RX_DV, RX_ER, RX_DATA, rcv_ack,
    input  addr, data, wr, ready, nbytes, err, crc_ok
  );
endinterface

// File: rtl/iob_eth_rx.sv
// MII receive engine: strips preamble/SFD, assembles bytes low nibble first into
// the frame buffer and holds per-frame status until acked. Define IOB_ETH_RX_CRC_EN for FCS checking.
module iob_eth_rx #(
  parameter int ADDR_W       = 11,
  parameter int MAX_NBYTES   = 1518,
  parameter int MIN_PREAMBLE = 2
) (
  input logic          RX_CLK,
  input logic          rst_n,
  iob_eth_rx_if.master rx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA_LO,
    S_DATA_HI,
    S_DONE,
    S_DROP_DONE,
    S_DROP
  } state_t;

  localparam logic [ADDR_W-1:0] MaxCnt = ADDR_W'(MAX_NBYTES);
  localparam logic [ADDR_W-1:0] One    = ADDR_W'(1);
  localparam logic [31:0]       MinPre = 32'(MIN_PREAMBLE);

  state_t            state_q, state_d;
  logic [3:0]        pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [3:0]        lo_nib_q, lo_nib_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              wr_q, wr_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] nbytes_q, nbytes_d;
  logic              err_q, err_d;
  logic              crc_ok_q, crc_ok_d;
  logic              overflow;
  logic              crc_match;
  logic [7:0]        byte_in;

  assign byte_in  = {rx.RX_DATA, lo_nib_q};
  // The next byte would be number MAX_NBYTES+1 once the count has reached the limit.
  assign overflow = (byte_cnt_q == MaxCnt);

  always_ff @(posedge RX_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wr_q       <= 1'b0;
      ready_q    <= 1'b0;
      nbytes_q   <= '0;
      err_q      <= 1'b0;
      crc_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_q       <= wr_d;
      ready_q    <= ready_d;
      nbytes_q   <= nbytes_d;
      err_q      <= err_d;
      crc_ok_q   <= crc_ok_d;
    end
  end

  always_ff @(posedge RX_CLK) begin
    lo_nib_q <= lo_nib_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:
        if (rx.RX_DV) state_d = (rx.RX_DATA == 4'h5) ? S_PREAMBLE : S_DROP;
      S_PREAMBLE:
        if (!rx.RX_DV)                 state_d = S_IDLE;
        else if (rx.RX_DATA == 4'hD)   state_d = ({28'd0, pre_cnt_q} >= MinPre) ? S_DATA_LO : S_DROP;
        else if (rx.RX_DATA != 4'h5)   state_d = S_DROP;
      S_DATA_LO:
        if (rx.RX_DV)                  state_d = S_DATA_HI;
        else                           state_d = (byte_cnt_q != '0) ? S_DONE : S_IDLE;
      S_DATA_HI:
        if (!rx.RX_DV)                 state_d = S_DONE;
        else if (overflow)             state_d = S_DROP_DONE;
        else                           state_d = S_DATA_LO;
      S_DONE:
        if (rx.rcv_ack)                state_d = rx.RX_DV ? S_DROP : S_IDLE;
      S_DROP_DONE:
        if (!rx.RX_DV)                 state_d = S_DONE;
      S_DROP:
        if (!rx.RX_DV)                 state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    lo_nib_d   = lo_nib_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_d       = 1'b0;
    ready_d    = ready_q;
    nbytes_d   = nbytes_q;
    err_d      = err_q;
    crc_ok_d   = crc_ok_q;
    unique case (state_q)
      S_IDLE: pre_cnt_d = 4'd1;
      S_PREAMBLE: begin
        if (rx.RX_DV && rx.RX_DATA == 4'h5 && pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        if (state_d == S_DATA_LO) begin
          byte_cnt_d = '0;
          err_d      = 1'b0;
        end
      end
      S_DATA_LO:
        if (rx.RX_DV) begin
          lo_nib_d = rx.RX_DATA;
          if (rx.RX_ER) err_d = 1'b1;
        end
      S_DATA_HI:
        // A missing high nibble or an over-long frame both mark the frame bad.
        if (!rx.RX_DV || overflow) begin
          err_d = 1'b1;
        end else begin
          wr_d       = 1'b1;
          addr_d     = byte_cnt_q;
          data_d     = byte_in;
          byte_cnt_d = byte_cnt_q + One;
          if (rx.RX_ER) err_d = 1'b1;
        end
      S_DONE:
        if (rx.rcv_ack) begin
          ready_d  = 1'b0;
          err_d    = 1'b0;
          crc_ok_d = 1'b0;
        end
      default: ;
    endcase
    if (state_q != S_DONE && state_d == S_DONE) begin
      ready_d  = 1'b1;
      nbytes_d = byte_cnt_q;
      crc_ok_d = crc_match;
    end
  end

`ifdef IOB_ETH_RX_CRC_EN
  localparam logic [31:0] CrcResidue = 32'hC704DD7B;

  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] bit_rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // The register shifts LSB-first; the residue constant is written MSB-first.
  assign crc_match = (bit_rev(crc_q) == CrcResidue);

  always_comb begin
    crc_d = crc_q;
    if (state_q == S_PREAMBLE && state_d == S_DATA_LO) crc_d = '1;
    else if (wr_d)                                        crc_d = crc32_byte(crc_q, byte_in);
  end

  always_ff @(posedge RX_CLK) begin
    crc_q <= crc_d;
  end
`else
  assign crc_match = 1'b1;
`endif

  assign rx.addr   = addr_q;
  assign rx.data   = data_q;
  assign rx.wr     = wr_q;
  assign rx.ready  = ready_q;
  assign rx.nbytes = nbytes_q;
  assign rx.err    = err_q;
  assign rx.crc_ok = crc_ok_q;

endmodule
